pix_capture_ctrl: RTL and testbench

Single-frame capture sequencer for the image-sensor pixel port. On a capture command it waits for a clean frame boundary and admits exactly one frame of pixels into a small internal FIFO. It presents the pixels downstream over a valid/ready stream and reports completion, overflow and pixel/line counts. It sits between the raw sensor inputs (pix_frameValid / pix_lineValid / pix_d) and the downstream pixel sink, all in the pix_clk domain.

---
 rtl/pix_capture_ctrl_if.sv | 11 +
 rtl/pix_capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_pix_capture_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pix_capture_ctrl_if.sv
// Downstream pixel stream: FIFO head pixel with a valid/ready handshake.
interface pix_capture_ctrl_if #(
   parameter int DataWidth = 12
);
   logic [DataWidth-1:0] q;
   logic                 qValid;
   logic                 qReady;

   modport master (output q, output qValid, input qReady);
   modport slave  (input q, input qValid, output qReady);
endinterface

// File: rtl/pix_capture_ctrl.sv
// Single-frame capture sequencer: waits for a clean frame boundary, admits
// one frame of sensor pixels into a small FIFO and streams them downstream.
module pix_capture_ctrl #(
   parameter int Depth          = 4,
   parameter int PixCountWidth  = 24,
   parameter int LineCountWidth = 12
) (
   input  logic                      pix_clk,
   input  logic                      pix_rst_n,
   input  logic                      pix_frameValid,
   input  logic                      pix_lineValid,
   input  logic [11:0]               pix_d,
   input  logic                      cmd_capture,
   input  logic                      cmd_abort,
   pix_capture_ctrl_if.master        stream,
   output logic                      status_busy,
   output logic                      status_done,
   output logic                      status_overflow,
   output logic [PixCountWidth-1:0]  status_pixCount,
   output logic [LineCountWidth-1:0] status_lineCount
);
   localparam int AW = $clog2(Depth);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_END,
      WAIT_START,
      CAPTURE,
      DRAIN
   } state_t;

   state_t       state;
   logic [11:0]  mem [Depth];
   logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [11:0]  q_reg, head_next;
   logic         q_valid_reg;
   logic         line_prev;
   logic         fifo_full, empty_next;
   logic         pop, push, drop, pixel_event, line_end;

   assign stream.q      = q_reg;
   assign stream.qValid = q_valid_reg;

   // Push/pop decisions, next pointers and the pixel that will sit at the head
   always_comb begin
      fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop         = q_valid_reg && stream.qReady;
      pixel_event = (state == WAIT_START || state == CAPTURE) && pix_frameValid
                    && pix_lineValid && !cmd_abort;
      // a full FIFO still accepts a pixel when the head leaves in the same cycle
      push        = pixel_event && (!fifo_full || pop);
      drop        = pixel_event && !push;
      line_end    = line_prev && !pix_lineValid && (state == CAPTURE) && !cmd_abort;
      if (cmd_abort) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         wr_ptr_next = wr_ptr + {{AW{1'b0}}, push};
         rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};
      end
      empty_next = (wr_ptr_next == rd_ptr_next);
      // bypass the incoming pixel when it lands directly in the head slot
      if (push && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0]))
         head_next = pix_d;
      else
         head_next = mem[rd_ptr_next[AW-1:0]];
   end

   // Pixel storage write port
   always_ff @(posedge pix_clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= pix_d;
   end

   // FIFO pointers, registered head pixel and line-valid history
   always_ff @(posedge pix_clk or negedge pix_rst_n) begin
      if (!pix_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         q_reg       <= '0;
         q_valid_reg <= 1'b0;
         line_prev   <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_next;
         rd_ptr      <= rd_ptr_next;
         q_valid_reg <= !empty_next;
         if (!empty_next)
            q_reg <= head_next;
         line_prev   <= pix_lineValid;
      end
   end

   // Capture sequencer with its status outputs
   always_ff @(posedge pix_clk or negedge pix_rst_n) begin
      if (!pix_rst_n) begin
         state            <= IDLE;
         status_busy      <= 1'b0;
         status_done      <= 1'b0;
         status_overflow  <= 1'b0;
         status_pixCount  <= '0;
         status_lineCount <= '0;
      end else begin
         if (drop)
            status_overflow <= 1'b1;
         if (push && (status_pixCount != '1))
            status_pixCount <= status_pixCount + PixCountWidth'(1);
         if (line_end && (status_lineCount != '1))
            status_lineCount <= status_lineCount + LineCountWidth'(1);

         if (cmd_abort) begin
            state       <= IDLE;
            status_busy <= 1'b0;
            status_done <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_capture) begin
                     status_busy      <= 1'b1;
                     status_done      <= 1'b0;
                     status_overflow  <= 1'b0;
                     status_pixCount  <= '0;
                     status_lineCount <= '0;
                     // never start in the middle of a frame
                     state <= pix_frameValid ? WAIT_END : WAIT_START;
                  end
               end
               WAIT_END: begin
                  if (!pix_frameValid)
                     state <= WAIT_START;
               end
               WAIT_START: begin
                  if (pix_frameValid)
                     state <= CAPTURE;
               end
               CAPTURE: begin
                  if (!pix_frameValid)
                     state <= DRAIN;
               end
               DRAIN: begin
                  if (empty_next) begin
                     state       <= IDLE;
                     status_busy <= 1'b0;
                     status_done <= 1'b1;
                  end
               end
               default: begin
                  state       <= IDLE;
                  status_busy <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pix_capture_ctrl.sv
// Randomised bench for pix_capture_ctrl against a queue-based reference model.
module tb_pix_capture_ctrl;
   localparam int Depth = 4;

   localparam int M_IDLE  = 0;
   localparam int M_SKIP  = 1;
   localparam int M_ARMED = 2;
   localparam int M_TAKE  = 3;
   localparam int M_FLUSH = 4;

   logic        pix_clk = 1'b0;
   logic        pix_rst_n = 1'b0;
   logic        fv = 1'b0;
   logic        lv = 1'b0;
   logic [11:0] d = '0;
   logic        cap = 1'b0;
   logic        abort = 1'b0;
   logic        busy, done, ovf;
   logic [23:0] pcnt;
   logic [11:0] lcnt;

   pix_capture_ctrl_if bus ();

   pix_capture_ctrl #(.Depth(Depth), .PixCountWidth(24), .LineCountWidth(12)) dut (
      .pix_clk          (pix_clk),
      .pix_rst_n        (pix_rst_n),
      .pix_frameValid   (fv),
      .pix_lineValid    (lv),
      .pix_d            (d),
      .cmd_capture      (cap),
      .cmd_abort        (abort),
      .stream           (bus),
      .status_busy      (busy),
      .status_done      (done),
      .status_overflow  (ovf),
      .status_pixCount  (pcnt),
      .status_lineCount (lcnt)
   );

   always #5 pix_clk = ~pix_clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   int          m_phase = M_IDLE;
   logic [11:0] m_q[$];
   bit          m_done = 0;
   bit          m_ovf = 0;
   int unsigned m_pix = 0;
   int unsigned m_line = 0;
   bit          m_prev_lv = 0;

   bit          rnd_ready = 0;
   int          cap_cd = 0;
   int          abort_cd = 0;
   logic [11:0] pix_val = 12'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = M_IDLE;
      m_q.delete();
      m_done = 0;
      m_ovf = 0;
      m_pix = 0;
      m_line = 0;
      m_prev_lv = 0;
   endtask

   // one clock edge of the reference behaviour, using the inputs held at that edge
   task automatic model_edge();
      bit pop, prev;
      int sz;
      pop = (m_q.size() > 0) && bus.qReady;
      prev = m_prev_lv;
      m_prev_lv = lv;
      if (abort) begin
         m_phase = M_IDLE;
         m_q.delete();
         m_done = 0;
      end else begin
         sz = m_q.size();
         if (pop) begin
            $display("pop q=%0d", m_q[0]);
            void'(m_q.pop_front());
         end
         if ((m_phase == M_ARMED || m_phase == M_TAKE) && fv && lv) begin
            if (sz < Depth || pop) begin
               m_q.push_back(d);
               if (m_pix < 24'hFFFFFF) m_pix++;
            end else begin
               m_ovf = 1;
            end
         end
         if (m_phase == M_TAKE && prev && !lv && m_line < 12'hFFF) m_line++;
         case (m_phase)
            M_IDLE: if (cap) begin
               m_done = 0; m_ovf = 0; m_pix = 0; m_line = 0;
               m_phase = fv ? M_SKIP : M_ARMED;
            end
            M_SKIP:  if (!fv) m_phase = M_ARMED;
            M_ARMED: if (fv) m_phase = M_TAKE;
            M_TAKE:  if (!fv) m_phase = M_FLUSH;
            default: if (m_q.size() == 0) begin
               m_phase = M_IDLE;
               m_done = 1;
               $display("capture done pixels=%0d lines=%0d overflow=%0d", m_pix, m_line, m_ovf);
            end
         endcase
      end
   endtask

   task automatic compare();
      check("qValid", bus.qValid, (m_q.size() > 0));
      if (m_q.size() > 0) check("q", bus.q, m_q[0]);
      check("busy", busy, (m_phase != M_IDLE));
      check("done", done, m_done);
      check("overflow", ovf, m_ovf);
      check("pixCount", pcnt, m_pix);
      check("lineCount", lcnt, m_line);
   endtask

   task automatic tick();
      @(posedge pix_clk);
      model_edge();
      #1;
      compare();
      cap = 1'b0;
      abort = 1'b0;
      if (cap_cd > 0) begin cap_cd--; if (cap_cd == 0) cap = 1'b1; end
      if (abort_cd > 0) begin abort_cd--; if (abort_cd == 0) abort = 1'b1; end
      if (rnd_ready) bus.qReady = ($urandom_range(3) != 0);
   endtask

   task automatic pulse_cap();
      cap = 1'b1;
      tick();
   endtask

   task automatic frame(input int lines, input int ppl);
      fv = 1'b1;
      tick();
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            lv = 1'b1;
            d = pix_val;
            pix_val = pix_val + 12'd1;
            tick();
         end
         lv = 1'b0;
         tick();
      end
      fv = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && m_phase != M_IDLE; i++) tick();
      check("drain_timeout", busy, 1'b0);
   endtask

   initial begin
      bus.qReady = 1'b0;
      #3;
      check("rst_qValid", bus.qValid, 0);
      check("rst_q", bus.q, 0);
      check("rst_busy", busy, 0);
      check("rst_pixCount", pcnt, 0);
      #4 pix_rst_n = 1'b1;

      // basic 3x4 frame, sink always ready
      bus.qReady = 1'b1;
      tick();
      pulse_cap();
      pix_val = 12'd1;
      frame(3, 4);
      wait_idle();
      check("t1_pixCount", pcnt, 12);
      check("t1_lineCount", lcnt, 3);
      check("t1_done", done, 1);

      // capture requested mid-frame: rest of frame skipped, next frame taken
      cap_cd = 4;
      frame(2, 3);
      frame(2, 5);
      wait_idle();
      check("t2_pixCount", pcnt, 10);

      // sink stalled: 4 stored, 2 dropped
      bus.qReady = 1'b0;
      pulse_cap();
      frame(1, 6);
      check("t3_overflow", ovf, 1);
      check("t3_pixCount", pcnt, 4);
      bus.qReady = 1'b1;
      wait_idle();
      check("t3_done", done, 1);

      // FIFO full with simultaneous push/pop every cycle
      bus.qReady = 1'b0;
      pulse_cap();
      fv = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         lv = 1'b1;
         d = pix_val;
         pix_val = pix_val + 12'd1;
         if (i == 4) bus.qReady = 1'b1;
         tick();
      end
      lv = 1'b0; tick();
      fv = 1'b0; tick();
      wait_idle();
      check("t4_overflow", ovf, 0);
      check("t4_pixCount", pcnt, 10);

      // abort during capture with 2 entries queued
      bus.qReady = 1'b0;
      pulse_cap();
      fv = 1'b1;
      tick();
      lv = 1'b1;
      for (int i = 0; i < 2; i++) begin d = pix_val; pix_val++; tick(); end
      abort = 1'b1;
      tick();
      check("t5_qValid", bus.qValid, 0);
      check("t5_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin d = pix_val; pix_val++; tick(); end
      check("t5_pixCount", pcnt, 2);
      lv = 1'b0; fv = 1'b0; tick();

      // asynchronous reset mid-drain
      pulse_cap();
      frame(1, 3);
      #2 pix_rst_n = 1'b0;
      #1;
      check("t6_qValid", bus.qValid, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_pixCount", pcnt, 0);
      check("t6_lineCount", lcnt, 0);
      model_reset();
      #2 pix_rst_n = 1'b1;
      bus.qReady = 1'b1;
      pulse_cap();
      frame(2, 3);
      wait_idle();
      check("t6_restart", pcnt, 6);

      // randomised captures, random sink stalls, occasional abort
      rnd_ready = 1;
      for (int it = 0; it < 25; it++) begin
         int l1, p1, l2, p2;
         l1 = $urandom_range(3, 1); p1 = $urandom_range(6, 1);
         l2 = $urandom_range(3, 1); p2 = $urandom_range(6, 1);
         if ($urandom_range(1) == 0) pulse_cap();
         else cap_cd = $urandom_range(1 + l1 * (p1 + 1), 1);
         if ($urandom_range(5) == 0) abort_cd = $urandom_range(15, 2);
         frame(l1, p1);
         frame(l2, p2);
         cap_cd = 0;
         abort_cd = 0;
         if (m_phase == M_SKIP || m_phase == M_ARMED) begin
            abort = 1'b1;
            tick();
         end
         wait_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
